exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/y86_pkg.sv | 59 +++++
 rtl/exec_stage_alu64.sv | 36 +++
 rtl/exec_stage.sv | 92 +++++++++
 tb/tb_exec_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU and condition function codes,
// the RNONE register id and the condition-code record used by the execute stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_t;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Branch / conditional-move predicate; unknown condition codes never fire.
  function automatic logic cond_eval(input cc_t c, input logic [3:0] fn);
    logic lt;
    lt = c.sf ^ c.of;
    case (fn)
      C_YES:   return 1'b1;
      C_LE:    return lt | c.zf;
      C_L:     return lt;
      C_E:     return c.zf;
      C_NE:    return !c.zf;
      C_GE:    return !lt;
      C_G:     return !lt && !c.zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_stage_alu64.sv
// Combinational 64-bit ALU (add, sub, and, xor) with signed-overflow output.
// EXEC_OF_FLAG_EN: when defined, of reports overflow; otherwise it is tied to 0.
module alu64
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_fn_t     fn,
  output logic [63:0] result,
  output logic        of
);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fn)
      ALU_ADD: begin
        result = b + a;
`ifdef EXEC_OF_FLAG_EN
        of = (a[63] == b[63]) && (result[63] != a[63]);
`endif
      end
      ALU_SUB: begin
        result = b - a;
`ifdef EXEC_OF_FLAG_EN
        of = (a[63] != b[63]) && (result[63] != b[63]);
`endif
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = a & b;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes and a one-deep
// valid/ready output register. Overflow flag gated by EXEC_OF_FLAG_EN (see alu64).
module exec_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] val_a,
  input  logic [63:0] val_b,
  input  logic [63:0] val_c,
  input  logic [3:0]  dst_e,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] val_e,
  output logic        cnd,
  output logic [3:0]  dst_e_out,
  output logic [3:0]  icode_out,
  output logic [2:0]  cc
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_r;
  logic        alu_of;
  alu_fn_t     alu_fn;
  logic        cnd_next;
  logic        xfer;
  cc_t         cc_q;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign cc       = cc_q;

  always_comb begin
    alu_a = '0;
    case (icode)
      IRRMOVQ, IOPQ:             alu_a = val_a;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = val_c;
      ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      IRET, IPOPQ:               alu_a = 64'd8;
      default:                   alu_a = '0;
    endcase

    alu_b = (icode == IRRMOVQ || icode == IIRMOVQ) ? '0 : val_b;

    // Undefined OPq function codes fall back to and, but still set flags.
    alu_fn = ALU_ADD;
    if (icode == IOPQ)
      alu_fn = (ifun > 4'd3) ? ALU_AND : alu_fn_t'(ifun[1:0]);

    // Predicate sees the flags as they stand before this edge's update.
    cnd_next = (icode == IRRMOVQ || icode == IJXX) && cond_eval(cc_q, ifun);
  end

  alu64 u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_r),
    .of     (alu_of)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      val_e     <= '0;
      cnd       <= 1'b0;
      dst_e_out <= RNONE;
      icode_out <= INOP;
      cc_q      <= CC_RESET;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      val_e     <= alu_r;
      cnd       <= cnd_next;
      dst_e_out <= (icode == IRRMOVQ && !cnd_next) ? RNONE : dst_e;
      icode_out <= icode;
      if (icode == IOPQ)
        cc_q <= '{zf: (alu_r == '0), sf: alu_r[63], of: alu_of};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: expectations are predicted when an instruction
// is driven and compared when it appears on the output register.
module tb_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic [63:0] val_c;
  logic [3:0]  dst_e;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] val_e;
  logic        cnd;
  logic [3:0]  dst_e_out;
  logic [3:0]  icode_out;
  logic [2:0]  cc;

  typedef struct {
    logic [63:0] val_e;
    logic        cnd;
    logic [3:0]  dst;
    logic [3:0]  icode;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_exp;
  logic [2:0] m_cc;
  int         passed;
  int         total;

  exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .val_c     (val_c),
    .dst_e     (dst_e),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .val_e     (val_e),
    .cnd       (cnd),
    .dst_e_out (dst_e_out),
    .icode_out (icode_out),
    .cc        (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the result of one instruction, update the model flags, drive the inputs.
  task automatic predict_and_drive(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c, input logic [3:0] d);
    exp_t        e;
    logic [63:0] x, y, r;
    logic        of, lt, zf, sf, take;
    case (ic)
      4'h2, 4'h6:       x = a;
      4'h3, 4'h4, 4'h5: x = c;
      4'h8, 4'hA:       x = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       x = 64'd8;
      default:          x = 64'd0;
    endcase
    y  = (ic == 4'h2 || ic == 4'h3) ? 64'd0 : b;
    of = 1'b0;
    r  = y + x;
    if (ic == 4'h6) begin
      case (fn)
        4'h0: of = (x[63] == y[63]) && (r[63] != x[63]);
        4'h1: begin r = y - x; of = (x[63] != y[63]) && (r[63] != y[63]); end
        4'h3: r = x ^ y;
        default: r = x & y;
      endcase
`ifndef EXEC_OF_FLAG_EN
      of = 1'b0;
`endif
    end
    zf = m_cc[2];
    sf = m_cc[1];
    lt = m_cc[1] ^ m_cc[0];
    case (fn)
      4'h0: take = 1'b1;
      4'h1: take = lt | zf;
      4'h2: take = lt;
      4'h3: take = zf;
      4'h4: take = !zf;
      4'h5: take = !lt;
      4'h6: take = !lt && !zf;
      default: take = 1'b0;
    endcase
    e.val_e = r;
    e.cnd   = (ic == 4'h2 || ic == 4'h7) ? take : 1'b0;
    e.dst   = (ic == 4'h2 && !e.cnd) ? 4'hF : d;
    e.icode = ic;
    sb.push_back(e);
    if (ic == 4'h6) m_cc = {(r == 64'd0), r[63], of};
    if (sf === 1'bx) m_cc = m_cc;
    icode    = ic;
    ifun     = fn;
    val_a    = a;
    val_b    = b;
    val_c    = c;
    dst_e    = d;
    in_valid = 1'b1;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    total++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      $display("FAIL %s out_valid: got %b (queued %0d), want 1", tag, out_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    passed++;
    e = sb.pop_front();
    last_exp = e;
    total++;
    if (val_e !== e.val_e) $display("FAIL %s val_e: got %h want %h", tag, val_e, e.val_e);
    else passed++;
    total++;
    if (cnd !== e.cnd) $display("FAIL %s cnd: got %b want %b", tag, cnd, e.cnd);
    else passed++;
    total++;
    if (dst_e_out !== e.dst) $display("FAIL %s dst_e_out: got %h want %h", tag, dst_e_out, e.dst);
    else passed++;
    total++;
    if (icode_out !== e.icode) $display("FAIL %s icode_out: got %h want %h", tag, icode_out, e.icode);
    else passed++;
    total++;
    if (cc !== m_cc) $display("FAIL %s cc: got %b want %b", tag, cc, m_cc);
    else passed++;
  endtask

  task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [3:0] d);
    predict_and_drive(ic, fn, a, b, c, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pop_compare(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    icode = 4'h6; ifun = 4'h0; val_a = 64'd1; val_b = 64'd2;
    #22;
    total++;
    if (out_valid !== 1'b0 || val_e !== 64'd0 || cnd !== 1'b0)
      $display("FAIL reset_out: got valid=%b val_e=%h cnd=%b want 0/0/0", out_valid, val_e, cnd);
    else passed++;
    total++;
    if (dst_e_out !== 4'hF || icode_out !== 4'h1)
      $display("FAIL reset_ids: got dst=%h icode=%h want F/1", dst_e_out, icode_out);
    else passed++;
    total++;
    if (cc !== 3'b100) $display("FAIL reset_cc: got %b want 100", cc);
    else passed++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_opq();
    send("add_ovf", 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
    send("sub_zero", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3);
    send("cmovle_taken", 4'h2, 4'h1, 64'h1234, 64'd99, 64'd0, 4'h3);
    send("and_d1", 4'h6, 4'h2, 64'hF5, 64'd211, 64'd0, 4'h4);
    send("je_not_taken", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'h5);
    send("cmovl_rnone", 4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h6);
    send("opq_ifun5_and", 4'h6, 4'h5, 64'hF0, 64'h0F, 64'd0, 4'h7);
    send("jxx_ifun7", 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'h8);
    send("irmovq", 4'h3, 4'h0, 64'd0, 64'd77, 64'hDEAD_BEEF, 4'h9);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL idle_clear: got out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_stack();
    send("pushq", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    send("popq", 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
  endtask

  task automatic test_back_to_back();
    predict_and_drive(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h1);
    @(posedge clk); #1;
    pop_compare("b2b_sub_neg");
    predict_and_drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'h2);
    @(posedge clk); #1;
    pop_compare("b2b_jl");
    predict_and_drive(4'h6, 4'h3, 64'h5A, 64'h5A, 64'd0, 4'h3);
    @(posedge clk); #1;
    pop_compare("b2b_xor_zero");
    predict_and_drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'h4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pop_compare("b2b_je");
  endtask

  task automatic test_stall();
    send("stall_a", 4'h6, 4'h0, 64'd10, 64'd20, 64'd0, 4'h5);
    out_ready = 1'b0;
    predict_and_drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h4242, 4'h6);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || val_e !== last_exp.val_e || icode_out !== last_exp.icode ||
          dst_e_out !== last_exp.dst)
        $display("FAIL stall_hold[%0d]: got valid=%b val_e=%h icode=%h dst=%h want 1/%h/%h/%h",
                 i, out_valid, val_e, icode_out, dst_e_out,
                 last_exp.val_e, last_exp.icode, last_exp.dst);
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pop_compare("stall_b");
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL stall_no_dup: got out_valid=%b queued=%0d want 0/0", out_valid, sb.size());
    else passed++;
  endtask

  task automatic test_flush();
    logic [2:0] cc_before;
    send("pre_flush", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1);
    cc_before = m_cc;
    icode = 4'h6; ifun = 4'h1; val_a = 64'd3; val_b = 64'd5; dst_e = 4'h2;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (cc !== cc_before) $display("FAIL flush_cc: got %b want %b", cc, cc_before);
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    send("pre_rst", 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3);
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || val_e !== 64'd0 || cnd !== 1'b0 ||
        dst_e_out !== 4'hF || icode_out !== 4'h1 || cc !== 3'b100)
      $display("FAIL rst_mid_stall: got %b/%h/%b/%h/%h/%b want 0/0/0/F/1/100",
               out_valid, val_e, cnd, dst_e_out, icode_out, cc);
    else passed++;
    m_cc = 3'b100;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send("post_rst", 4'h6, 4'h1, 64'd1, 64'd4, 64'd0, 4'h2);
  endtask

  initial begin
    passed = 0;
    total = 0;
    m_cc = 3'b100;
    in_valid = 1'b0;
    icode = 4'h1; ifun = 4'h0;
    val_a = '0; val_b = '0; val_c = '0;
    dst_e = 4'hF;
    flush = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_opq();
    test_stack();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
